// File: rtl/i4004_pkg.sv
// Shared types for the 4004-style bus sequencer: state enum,
// width defaults and the subcycle codes presented on phase.
package i4004_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int NIB_W_DEF  = 4;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_A1   = 4'd1,
    S_A2   = 4'd2,
    S_A3   = 4'd3,
    S_M1   = 4'd4,
    S_M2   = 4'd5,
    S_X1   = 4'd6,
    S_X2   = 4'd7,
    S_X3   = 4'd8
  } state_e;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_A1   = 3'd0;
  localparam logic [2:0] PH_A2   = 3'd1;
  localparam logic [2:0] PH_A3   = 3'd2;
  localparam logic [2:0] PH_M1   = 3'd3;
  localparam logic [2:0] PH_M2   = 3'd4;
  localparam logic [2:0] PH_X1   = 3'd5;
  localparam logic [2:0] PH_X2   = 3'd6;
  localparam logic [2:0] PH_X3   = 3'd7;

  function automatic logic [2:0] phase_of(input state_e s);
    logic [2:0] p;
    p = PH_IDLE;
    case (s)
      S_A1:    p = PH_A1;
      S_A2:    p = PH_A2;
      S_A3:    p = PH_A3;
      S_M1:    p = PH_M1;
      S_M2:    p = PH_M2;
      S_X1:    p = PH_X1;
      S_X2:    p = PH_X2;
      S_X3:    p = PH_X3;
      default: p = PH_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/i4004_bus_cycle.sv
// 4004 machine-cycle sequencer: A1-A3 address out, M1/M2 fetch, X1-X3 execute.
// Define I4004_STALL_EN to let run hold the bus in IDLE between cycles.
module i4004_bus_cycle
  import i4004_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NIB_W  = NIB_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [NIB_W-1:0]  data_in,
  input  logic [NIB_W-1:0]  exe_data,
  input  logic              exe_oe,
  output logic [NIB_W-1:0]  data_out,
  output logic              data_oe,
  output logic              sync_out,
  output logic [2:0]        phase,
  output logic [NIB_W-1:0]  opr_out,
  output logic [NIB_W-1:0]  opa_out,
  output logic              instr_valid,
  output logic [NIB_W-1:0]  x2_data,
  output logic [15:0]       cycle_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NIB_W-1:0]  opr_q, opr_d;
  logic [NIB_W-1:0]  opa_q, opa_d;
  logic [NIB_W-1:0]  x2_q, x2_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              run_eff;

`ifdef I4004_STALL_EN
  assign run_eff = run;
`else
  logic unused_run;
  assign unused_run = run;
  assign run_eff    = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    opr_d   = opr_q;
    opa_d   = opa_q;
    x2_d    = x2_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (run_eff) state_d = S_A1;
      S_A1:   state_d = S_A2;
      S_A2:   state_d = S_A3;
      S_A3:   state_d = S_M1;
      S_M1: begin
        opr_d   = data_in;
        state_d = S_M2;
      end
      S_M2: begin
        opa_d   = data_in;
        state_d = S_X1;
      end
      S_X1:   state_d = S_X2;
      S_X2: begin
        if (!exe_oe) x2_d = data_in;
        state_d = S_X3;
      end
      S_X3: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = run_eff ? S_A1 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Address is frozen for the whole machine cycle once A1 is entered
    if (state_d == S_A1 && state_q != S_A1) addr_d = addr_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      opr_q   <= '0;
      opa_q   <= '0;
      x2_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      x2_q    <= x2_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    data_oe  = 1'b0;
    data_out = '0;
    unique case (1'b1)
      state_q == S_A1: begin
        data_oe  = 1'b1;
        data_out = addr_q[NIB_W-1:0];
      end
      state_q == S_A2: begin
        data_oe  = 1'b1;
        data_out = addr_q[2*NIB_W-1:NIB_W];
      end
      state_q == S_A3: begin
        data_oe  = 1'b1;
        data_out = addr_q[3*NIB_W-1:2*NIB_W];
      end
      state_q == S_X2 && exe_oe: begin
        data_oe  = 1'b1;
        data_out = exe_data;
      end
      default: ;
    endcase
  end

  assign phase       = phase_of(state_q);
  assign sync_out    = (state_q == S_X3);
  assign instr_valid = (state_q == S_X1);
  assign opr_out     = opr_q;
  assign opa_out     = opa_q;
  assign x2_data     = x2_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_i4004_bus_cycle.sv
// Scoreboard bench for i4004_bus_cycle against a machine-cycle level model.
// Honours I4004_STALL_EN the same way the design does.
module tb_i4004_bus_cycle;

`ifdef I4004_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [11:0] addr_in = '0;
  logic [3:0]  data_in = '0;
  logic [3:0]  exe_data = '0;
  logic        exe_oe = 1'b0;
  logic [3:0]  data_out;
  logic        data_oe;
  logic        sync_out;
  logic [2:0]  phase;
  logic [3:0]  opr_out;
  logic [3:0]  opa_out;
  logic        instr_valid;
  logic [3:0]  x2_data;
  logic [15:0] cycle_count;

  always #5 clk = ~clk;

  i4004_bus_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .exe_data    (exe_data),
    .exe_oe      (exe_oe),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .sync_out    (sync_out),
    .phase       (phase),
    .opr_out     (opr_out),
    .opa_out     (opa_out),
    .instr_valid (instr_valid),
    .x2_data     (x2_data),
    .cycle_count (cycle_count)
  );

  typedef struct {
    logic [2:0]  ph;
    logic        oe;
    logic [3:0]  dout;
    logic        dchk;
    logic        sync;
    logic        iv;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [3:0]  x2;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: step 0 = idle, 1..8 = position within the machine cycle
  int          step  = 0;
  logic [11:0] m_addr = '0;
  logic [3:0]  m_opr = '0;
  logic [3:0]  m_opa = '0;
  logic [3:0]  m_x2  = '0;
  logic [15:0] m_cnt = '0;

  function automatic void chk(input string nm,
                              input logic [15:0] act,
                              input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("phase", 16'(phase), 16'(e.ph));
        chk("data_oe", 16'(data_oe), 16'(e.oe));
        if (e.dchk) chk("data_out", 16'(data_out), 16'(e.dout));
        chk("sync_out", 16'(sync_out), 16'(e.sync));
        chk("instr_valid", 16'(instr_valid), 16'(e.iv));
        chk("opr_out", 16'(opr_out), 16'(e.opr));
        chk("opa_out", 16'(opa_out), 16'(e.opa));
        chk("x2_data", 16'(x2_data), 16'(e.x2));
        chk("cycle_count", cycle_count, e.cnt);
      end
    end
  end

  task automatic tick(input logic r, input logic ru,
                      input logic [11:0] a, input logic [3:0] di,
                      input logic eo, input logic [3:0] ed,
                      input bit do_force, input bit do_release);
    exp_t e;
    logic run_eff;
    @(posedge clk);
    #1;
    rst = r; run = ru; addr_in = a;
    data_in = di; exe_oe = eo; exe_data = ed;
    if (do_force) begin
      force dut.cnt_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
    end
    if (do_release) release dut.cnt_q;
    e.ph   = (step == 0) ? 3'd0 : 3'(step - 1);
    e.oe   = (step >= 1 && step <= 3) || (step == 7 && eo);
    e.dout = 4'h0;
    if (step >= 1 && step <= 3) e.dout = 4'((m_addr >> (4 * (step - 1))) & 12'hF);
    else if (step == 7 && eo) e.dout = ed;
    e.dchk = !(step == 4 || step == 5 || (step == 7 && !eo));
    e.sync = (step == 8);
    e.iv   = (step == 6);
    e.opr  = m_opr;
    e.opa  = m_opa;
    e.x2   = m_x2;
    e.cnt  = m_cnt;
    q.push_back(e);
    run_eff = STALL ? ru : 1'b1;
    if (r) begin
      step = 0; m_addr = '0; m_opr = '0;
      m_opa = '0; m_x2 = '0; m_cnt = '0;
    end else begin
      if (step == 4) m_opr = di;
      if (step == 5) m_opa = di;
      if (step == 7 && !eo) m_x2 = di;
      if (step == 8) m_cnt = m_cnt + 16'd1;
      if (step == 0 || step == 8) begin
        if (run_eff) begin
          step = 1;
          m_addr = a;
        end else step = 0;
      end else step = step + 1;
    end
  endtask

  function automatic logic [3:0] rn();
    return 4'($urandom_range(15, 0));
  endfunction

  initial begin
    logic [11:0] a;
    logic [3:0]  di;
    bit          done;
    // reset, with run asserted too: reset must win
    tick(1, 1, 12'h123, rn(), 0, rn(), 0, 0);
    tick(1, 1, 12'h456, rn(), 1, rn(), 0, 0);
    // directed fetch of 0xABC, opcode 2/D, X2 write then X2 read
    for (int i = 0; i < 20; i++) begin
      a  = (step == 0 || step == 8) ? 12'hABC : 12'($urandom);
      di = (step == 4) ? 4'h2 : (step == 5) ? 4'hD
         : (step == 7) ? 4'h5 : rn();
      tick(0, 1, a, di, (step == 7 && m_cnt == 0), 4'h7, 0, 0);
    end
    // drop run at X3 and in idle, then resume
    for (int k = 0; k < 30; k++) begin
      tick(0, (k >= 25) || !(step == 0 || step == 8),
           12'($urandom), rn(), 1'($urandom), rn(), 0, 0);
    end
    // reset pulse while in M1
    done = 0;
    for (int i = 0; i < 20; i++) begin
      tick(!done && step == 4, 1, 12'($urandom), rn(),
           1'($urandom), rn(), 0, 0);
      if (step == 0) done = 1;
    end
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(49, 0) == 0, $urandom_range(3, 0) != 0,
           12'($urandom), rn(), 1'($urandom), rn(), 0, 0);
    end
    // counter wrap: preload 0xFFFF away from an X3 exit
    for (int i = 0; i < 20 && !(step >= 1 && step <= 6); i++)
      tick(0, 1, 12'($urandom), rn(), 1'($urandom), rn(), 0, 0);
    if (step >= 1 && step <= 6) begin
      tick(0, 1, 12'($urandom), rn(), 1'($urandom), rn(), 1, 0);
      tick(0, 1, 12'($urandom), rn(), 1'($urandom), rn(), 0, 1);
    end else begin
      n_bad++;
      $display("FAIL wrap_setup step=%0d", step);
    end
    for (int i = 0; i < 24; i++)
      tick(0, $urandom_range(1, 0) == 1, 12'($urandom), rn(),
           1'($urandom), rn(), 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
